// File: rtl/mult_shiftadd_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding,
// default operand width and the bit-counter width helper.
package mult_shiftadd_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold the value DATAWIDTH itself.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/mult_shiftadd_dp.sv
// Datapath of the shift-and-add multiplier: accumulator, multiplicand and
// multiplier shift registers, bit counter and the registered product.
module mult_shiftadd_dp
    import mult_shiftadd_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step,
    input  logic                   latch,
    input  logic [DATAWIDTH-1:0]   opa,
    input  logic [DATAWIDTH-1:0]   opb,
    output logic [2*DATAWIDTH-1:0] product,
    output logic                   cnt_zero
);

    localparam int PW = 2 * DATAWIDTH;
    localparam int CW = cnt_width(DATAWIDTH);

    logic [PW-1:0]        acc_reg, acc_next;
    logic [PW-1:0]        mcand_reg, mcand_next;
    logic [PW-1:0]        addend;
    logic [PW-1:0]        product_reg;
    logic [DATAWIDTH-1:0] mplier_reg, mplier_next;
    logic [CW-1:0]        cnt_reg, cnt_next;

    // Partial product: the shifted multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Next-state of the datapath: capture operands on load, one bit per step.
    always_comb begin
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        if (load) begin
            acc_next    = '0;
            mcand_next  = {{DATAWIDTH{1'b0}}, opa};
            mplier_next = opb;
            cnt_next    = CW'(DATAWIDTH);
        end else if (step) begin
            acc_next    = acc_reg + addend;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg - CW'(1);
        end
    end

    // Datapath registers; product only changes when the FSM latches a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            if (latch) begin
                product_reg <= acc_reg;
            end
        end
    end

    assign product  = product_reg;
    assign cnt_zero = (cnt_reg == '0);

endmodule

// File: rtl/mult_shiftadd.sv
// Unsigned shift-and-add multiplier: IDLE/CALC/DONE control FSM around the
// mult_shiftadd_dp datapath. Fixed latency of DATAWIDTH+1 cycles from start
// to the DONE cycle, independent of operand values.
module mult_shiftadd
    import mult_shiftadd_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATAWIDTH-1:0]   OpA,
    input  logic [DATAWIDTH-1:0]   OpB,
    output logic [2*DATAWIDTH-1:0] Product,
    output logic                   busy,
    output logic                   done,
    output logic                   lowWrOut
);

    state_t state_reg, state_next;
    logic   load, step, latch, cnt_zero;

    mult_shiftadd_dp #(
        .DATAWIDTH (DATAWIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .latch    (latch),
        .opa      (OpA),
        .opb      (OpB),
        .product  (Product),
        .cnt_zero (cnt_zero)
    );

    // State register; reset aborts any multiplication in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, datapath controls and status outputs decoded from the state.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        latch      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        lowWrOut   = 1'b1;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                // The zero-count cycle commits the finished accumulator.
                if (cnt_zero) begin
                    latch      = 1'b1;
                    state_next = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                lowWrOut   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_shiftadd.sv
// Self-checking bench for mult_shiftadd at DATAWIDTH 8 and 16: directed
// vector table, multi-cycle corner sequences and a random regression
// checked against plain a*b arithmetic.
module tb_mult_shiftadd;

    localparam int DW8     = 8;
    localparam int DW16    = 16;
    localparam int LAT8    = DW8 + 1;   // start edge to the DONE cycle
    localparam int LAT16   = DW16 + 1;
    localparam int PERIOD8 = DW8 + 3;   // start edge, DW8+1 to DONE, DONE cycle, one IDLE cycle

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  opa8, opb8;
    logic [15:0] opa16, opb16;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic        busy8, done8, lwr8;
    logic        busy16, done16, lwr16;

    int          vectors;
    int          miscompares;
    logic [15:0] last_p8;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[8];

    mult_shiftadd #(.DATAWIDTH(DW8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .OpA      (opa8),
        .OpB      (opb8),
        .Product  (prod8),
        .busy     (busy8),
        .done     (done8),
        .lowWrOut (lwr8)
    );

    mult_shiftadd #(.DATAWIDTH(DW16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .start    (start16),
        .OpA      (opa16),
        .OpB      (opb16),
        .Product  (prod16),
        .busy     (busy16),
        .done     (done16),
        .lowWrOut (lwr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One 8-bit multiplication with full cycle-by-cycle control checking.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input string tag);
        @(negedge clk);
        opa8   = a;
        opb8   = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        opa8   = 8'($urandom);   // operands must already be captured
        opb8   = 8'($urandom);
        for (int c = 0; c <= LAT8; c++) begin
            @(negedge clk);
            // {busy, done, lowWrOut}
            check({tag, " ctl"}, {busy8, done8, lwr8}, (c == LAT8) ? 3'b110 : 3'b101);
            if (c == LAT8 / 2) check({tag, " hold"}, prod8, last_p8);
        end
        check({tag, " product"}, prod8, exp_p);
        @(negedge clk);
        check({tag, " idle"}, {busy8, done8, lwr8}, 3'b001);
        last_p8 = exp_p;
        $display("op8  %s: 0x%02h * 0x%02h -> 0x%04h (required 0x%04h)", tag, a, b, prod8, exp_p);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
        @(negedge clk);
        opa16   = a;
        opb16   = b;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        opa16   = 16'($urandom);
        opb16   = 16'($urandom);
        for (int c = 0; c <= LAT16; c++) begin
            @(negedge clk);
            check("op16 ctl", {busy16, done16, lwr16}, (c == LAT16) ? 3'b110 : 3'b101);
        end
        check("op16 product", prod16, exp_p);
        $display("op16 rnd: 0x%04h * 0x%04h -> 0x%08h (required 0x%08h)", a, b, prod16, exp_p);
    endtask

    initial begin
        int ndone;
        int last;

        vectors     = 0;
        miscompares = 0;
        last_p8     = 16'h0;
        rst     = 1'b1;
        start8  = 1'b0;
        start16 = 1'b0;
        opa8    = '0;
        opb8    = '0;
        opa16   = '0;
        opb16   = '0;

        tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[1] = '{8'h00, 8'hA5, 16'h0000};
        tbl[2] = '{8'h80, 8'h01, 16'h0080};
        tbl[3] = '{8'h01, 8'h80, 16'h0080};
        tbl[4] = '{8'h07, 8'h06, 16'h002A};
        tbl[5] = '{8'h0C, 8'h0D, 16'h009C};
        tbl[6] = '{8'h01, 8'h01, 16'h0001};
        tbl[7] = '{8'hFF, 8'h00, 16'h0000};

        // Reset state
        #3;
        check("reset ctl8", {busy8, done8, lwr8}, 3'b001);
        check("reset prod8", prod8, 16'h0);
        check("reset ctl16", {busy16, done16, lwr16}, 3'b001);
        check("reset prod16", prod16, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_op8(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("tbl%0d", i));
        end

        // Second start during CALC is ignored; only the first result appears
        @(negedge clk);
        opa8 = 8'd12; opb8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        ndone = 0;
        for (int c = 0; c <= LAT8 + 8; c++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                check("ignore-start done cycle", c, LAT8);
                check("ignore-start product", prod8, 16'd156);
            end
            if (c == 2) begin
                opa8 = 8'd3; opb8 = 8'd3; start8 = 1'b1;
            end
            if (c == 3) start8 = 1'b0;
        end
        check("ignore-start done count", ndone, 1);
        last_p8 = 16'd156;
        $display("seq  ignore-start: 12*13 with restart attempt -> %0d done pulse(s), product %0d", ndone, prod8);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        opa8 = 8'd9; opb8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        check("pre-reset busy/product", {busy8, prod8}, {1'b1, last_p8});
        rst = 1'b1;
        #1;
        check("midcalc reset ctl", {busy8, done8, lwr8}, 3'b001);
        check("midcalc reset product", prod8, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        last_p8 = 16'h0;
        ndone = 0;
        for (int c = 0; c < 2 * PERIOD8; c++) begin
            @(negedge clk);
            if (done8 || !lwr8) ndone++;
        end
        check("midcalc reset no pulse", ndone, 0);
        $display("seq  midcalc-reset: 9*9 aborted, %0d stray pulse(s)", ndone);
        do_op8(8'd7, 8'd6, 16'd42, "after-reset");

        // start held high: back-to-back runs
        @(negedge clk);
        opa8 = 8'h10; opb8 = 8'h10; start8 = 1'b1;
        last  = -1;
        ndone = 0;
        for (int cyc = 0; cyc < 6 * PERIOD8; cyc++) begin
            @(negedge clk);
            if (done8) begin
                if (last >= 0) check("b2b period", cyc - last, PERIOD8);
                check("b2b product", prod8, 16'h0100);
                last = cyc;
                ndone++;
            end
        end
        start8 = 1'b0;
        check("b2b pulse count ok", (ndone >= 5), 1'b1);
        $display("seq  back-to-back: %0d done pulses, product 0x%04h", ndone, prod8);
        for (int c = 0; c < PERIOD8 + 2; c++) @(negedge clk);
        check("b2b final idle", {busy8, done8, lwr8}, 3'b001);
        last_p8 = 16'h0100;

        // Random regression against plain arithmetic
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            do_op8(a, b, 16'(a) * 16'(b), "rnd");
        end
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            do_op16(a, b, 32'(a) * 32'(b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
